// File: rtl/bcp_clause_tracker_if.sv
// Operation/event handshake bundle for the BCP clause tracker.
// The master side issues literal-assignment operations and drains events;
// the slave side is the tracker itself.
interface bcp_clause_tracker_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [IDX_W-1:0] op_clause;
  logic [CNT_W-1:0] op_size;
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_kind;
  logic [IDX_W-1:0] evt_clause;

  modport master (
    output op_valid, op_code, op_clause, op_size, evt_ready,
    input  op_ready, evt_valid, evt_kind, evt_clause
  );

  modport slave (
    input  op_valid, op_code, op_clause, op_size, evt_ready,
    output op_ready, evt_valid, evt_kind, evt_clause
  );
endinterface

// File: rtl/bcp_clause_tracker.sv
// Per-clause status engine: keeps size / falsified-literal count / satisfied
// flag for each clause and raises unit or conflict events from a single
// registered event slot.
module bcp_clause_tracker #(
  parameter int NUM_CLAUSES = 16,
  parameter int IDX_W       = 4,
  parameter int MAX_SIZE    = 8,
  parameter int CNT_W       = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  bcp_clause_tracker_if.slave   bus
);

  localparam logic [1:0] OP_INIT      = 2'b00;
  localparam logic [1:0] OP_FALSIFY   = 2'b01;
  localparam logic [1:0] OP_SATISFY   = 2'b10;
  localparam logic [1:0] OP_UNFALSIFY = 2'b11;

  localparam int              AW         = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam logic [CNT_W-1:0] MAX_SIZE_C = CNT_W'(MAX_SIZE);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  logic [CNT_W-1:0] size_reg [NUM_CLAUSES];
  logic [CNT_W-1:0] cnt_reg  [NUM_CLAUSES];
  logic             sat_reg  [NUM_CLAUSES];

  logic             evt_valid_reg;
  logic             evt_kind_reg;
  logic [IDX_W-1:0] evt_clause_reg;

  logic             in_range;
  logic [AW-1:0]    rd_idx;
  logic             accept;
  logic             wr_en;
  logic [CNT_W-1:0] cur_size, cur_cnt;
  logic             cur_sat;
  logic [CNT_W-1:0] nxt_size, nxt_cnt;
  logic             nxt_sat;
  logic             ev_fire, ev_kind;

  // Out-of-range clause indices only exist when the index space is larger
  // than the clause table; otherwise the check folds away.
  if (NUM_CLAUSES >= (1 << IDX_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (bus.op_clause < IDX_W'(NUM_CLAUSES));
  end

  assign rd_idx   = bus.op_clause[AW-1:0];
  assign cur_size = size_reg[rd_idx];
  assign cur_cnt  = cnt_reg[rd_idx];
  assign cur_sat  = sat_reg[rd_idx];

  // A free or simultaneously drained slot lets the next op in.
  assign bus.op_ready = !evt_valid_reg || bus.evt_ready;
  assign accept       = bus.op_valid && bus.op_ready;
  assign wr_en        = accept && in_range;

  assign bus.evt_valid  = evt_valid_reg;
  assign bus.evt_kind   = evt_kind_reg;
  assign bus.evt_clause = evt_clause_reg;

  // Read-modify-write of the addressed clause and event decision.
  always_comb begin
    nxt_size = cur_size;
    nxt_cnt  = cur_cnt;
    nxt_sat  = cur_sat;
    ev_fire  = 1'b0;
    ev_kind  = 1'b0;
    case (bus.op_code)
      OP_INIT: begin
        nxt_size = (bus.op_size > MAX_SIZE_C) ? MAX_SIZE_C : bus.op_size;
        nxt_cnt  = '0;
        nxt_sat  = 1'b0;
        if (nxt_size == '0) begin
          ev_fire = 1'b1;
          ev_kind = 1'b1;
        end else if (nxt_size == ONE_C) begin
          ev_fire = 1'b1;
        end
      end
      OP_FALSIFY: begin
        // Saturates at size; only a real change can raise an event.
        if (cur_cnt != cur_size) begin
          nxt_cnt = cur_cnt + ONE_C;
          if (!cur_sat) begin
            if (nxt_cnt == cur_size - ONE_C) begin
              ev_fire = 1'b1;
            end else if (nxt_cnt == cur_size) begin
              ev_fire = 1'b1;
              ev_kind = 1'b1;
            end
          end
        end
      end
      OP_SATISFY: begin
        nxt_sat = 1'b1;
      end
      OP_UNFALSIFY: begin
        if (cur_cnt != '0) begin
          nxt_cnt = cur_cnt - ONE_C;
        end
      end
      default: ;
    endcase
  end

  // Clause table update for accepted in-range operations.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLAUSES; i++) begin
        size_reg[i] <= '0;
        cnt_reg[i]  <= '0;
        sat_reg[i]  <= 1'b0;
      end
    end else if (wr_en) begin
      size_reg[rd_idx] <= nxt_size;
      cnt_reg[rd_idx]  <= nxt_cnt;
      sat_reg[rd_idx]  <= nxt_sat;
    end
  end

  // Single event slot: load on a firing op, clear on consume, else hold.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_reg  <= 1'b0;
      evt_kind_reg   <= 1'b0;
      evt_clause_reg <= '0;
    end else if (wr_en && ev_fire) begin
      evt_valid_reg  <= 1'b1;
      evt_kind_reg   <= ev_kind;
      evt_clause_reg <= bus.op_clause;
    end else if (bus.evt_ready) begin
      evt_valid_reg  <= 1'b0;
    end
  end

endmodule
